// File: rtl/nonce_report_pkg.sv
// ---------------------------------------------------------------------------
// nonce_report_pkg
// Shared definitions for the golden-nonce UART reporter:
//   - tx_state_e       : serializer FSM states
//   - BITS_PER_BYTE    : data bits per UART character (8N1)
//   - BYTES_PER_NONCE  : characters per reported nonce
//   - NONCE_WIDTH      : nonce width in bits
//   - DEFAULT_*        : default parameter values of the top module
//   - counter_width()  : width of a counter that holds 0..n-1
// ---------------------------------------------------------------------------
package nonce_report_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int BITS_PER_BYTE           = 8;
    localparam int BYTES_PER_NONCE         = 4;
    localparam int NONCE_WIDTH             = BITS_PER_BYTE * BYTES_PER_NONCE;
    localparam int DEFAULT_CLKS_PER_BIT    = 868;
    localparam int DEFAULT_FIFO_DEPTH_LOG2 = 2;

    // Width of a counter running 0..n-1 (at least one bit).
    function automatic int counter_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nonce_fifo.sv
// ---------------------------------------------------------------------------
// nonce_fifo
// Synchronous FIFO with registered occupancy and a combinational head so the
// consumer can pop and capture the head word on the same edge.
//   i_clk    : clock
//   i_srst   : synchronous active-high reset (empties the FIFO)
//   i_push   : write i_data (ignored when full unless popping this cycle)
//   i_data   : write data
//   i_pop    : remove head (ignored when empty)
//   o_head   : current head word
//   o_count  : occupancy, 0..2**DEPTH_LOG2
//   o_full   : occupancy equals depth
//   o_empty  : occupancy is zero
// ---------------------------------------------------------------------------
module nonce_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  i_clk,
    input  logic                  i_srst,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are exactly DEPTH_LOG2 bits wide, so they wrap on their own.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/nonce_uart_reporter.sv
// ---------------------------------------------------------------------------
// nonce_uart_reporter
// Buffers golden nonces in a small FIFO and reports each one over an 8N1 UART
// as four characters, most significant byte first, each byte LSB first.
//   hash_clk    : sole clock
//   reset       : synchronous active-high reset, abandons any frame
//   nonce_valid : one-cycle strobe, nonce is present
//   nonce       : 32-bit golden nonce
//   tx          : UART line, idle high
//   busy        : serializer active or FIFO non-empty
//   overflow    : sticky, a nonce was dropped on a full FIFO
//   fifo_count  : FIFO occupancy
// Build option: define NONCE_DEDUP_EN to silently drop a nonce equal to the
// last accepted one (tracked since reset).
// ---------------------------------------------------------------------------
module nonce_uart_reporter
    import nonce_report_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = DEFAULT_FIFO_DEPTH_LOG2
) (
    input  logic                       hash_clk,
    input  logic                       reset,
    input  logic                       nonce_valid,
    input  logic [NONCE_WIDTH-1:0]     nonce,
    output logic                       tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count
);
    localparam int               BAUD_W    = counter_width(CLKS_PER_BIT);
    localparam int               BIT_W     = counter_width(BITS_PER_BYTE);
    localparam int               BYTE_W    = counter_width(BYTES_PER_NONCE);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(BITS_PER_BYTE - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(BYTES_PER_NONCE - 1);

    tx_state_e              r_state,  w_state_next;
    logic [BAUD_W-1:0]      r_baud,   w_baud_next;
    logic [BIT_W-1:0]       r_bit,    w_bit_next;
    logic [BYTE_W-1:0]      r_byte,   w_byte_next;
    logic [NONCE_WIDTH-1:0] r_shift,  w_shift_next;
    logic                   r_tx,     w_tx_next;
    logic                   r_overflow;

    logic [NONCE_WIDTH-1:0]   w_fifo_head;
    logic [FIFO_DEPTH_LOG2:0] w_fifo_count;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_pop;
    logic                     w_dup;
    logic                     w_push_req;
    logic                     w_push_ok;
    logic                     w_baud_last;
    logic [BITS_PER_BYTE-1:0] w_cur_byte;

`ifdef NONCE_DEDUP_EN
    logic [NONCE_WIDTH-1:0] r_last_nonce;
    logic                   r_last_valid;

    assign w_dup = r_last_valid && (nonce == r_last_nonce);

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_last_valid <= 1'b0;
            r_last_nonce <= '0;
        end else if (w_push_ok) begin
            r_last_valid <= 1'b1;
            r_last_nonce <= nonce;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    assign w_pop      = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_push_req = nonce_valid && !w_dup;
    assign w_push_ok  = w_push_req && (!w_fifo_full || w_pop);

    nonce_fifo #(
        .WIDTH      (NONCE_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clk   (hash_clk),
        .i_srst  (reset),
        .i_push  (w_push_ok),
        .i_data  (nonce),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_baud_last = (r_baud == BAUD_LAST);
    // The byte on the wire always sits in the top of the shift word.
    assign w_cur_byte  = r_shift[NONCE_WIDTH-1 -: BITS_PER_BYTE];

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_byte_next  = r_byte;
        w_shift_next = r_shift;
        w_tx_next    = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_shift_next = w_fifo_head;
                    w_byte_next  = '0;
                    w_baud_next  = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tx_next = 1'b0;
                if (w_baud_last) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = ST_DATA;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_DATA: begin
                w_tx_next = w_cur_byte[r_bit];
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (r_bit == BIT_LAST) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit + 1'b1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (r_byte != BYTE_LAST) begin
                        w_byte_next  = r_byte + 1'b1;
                        w_shift_next = {r_shift[NONCE_WIDTH-BITS_PER_BYTE-1:0],
                                        {BITS_PER_BYTE{1'b0}}};
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // tx is registered from the current state, so the line follows the FSM by
    // one cycle: a pop at edge N+1 drives the start bit from edge N+2.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_baud     <= '0;
            r_bit      <= '0;
            r_byte     <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_byte  <= w_byte_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
            if (w_push_req && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != ST_IDLE) || !w_fifo_empty;
    assign overflow   = r_overflow;
    assign fifo_count = w_fifo_count;

endmodule

// File: tb/tb_nonce_uart_reporter.sv
// ---------------------------------------------------------------------------
// tb_nonce_uart_reporter
// Directed scenarios plus a randomized phase for nonce_uart_reporter with
// CLKS_PER_BIT=4 and a depth-4 FIFO. A queue-based model tracks buffered
// nonces and the time each frame occupies the serializer; a UART receiver
// decodes the tx line and the decoded nonces are compared with the model.
// Honours NONCE_DEDUP_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_nonce_uart_reporter;
    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
    localparam int FRAME = 40 * CPB;
`ifdef NONCE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic          hash_clk    = 1'b0;
    logic          reset       = 1'b1;
    logic          nonce_valid = 1'b0;
    logic [31:0]   nonce       = '0;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [DL2:0]  fifo_count;

    nonce_uart_reporter #(
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH_LOG2 (DL2)
    ) dut (
        .hash_clk    (hash_clk),
        .reset       (reset),
        .nonce_valid (nonce_valid),
        .nonce       (nonce),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 hash_clk = ~hash_clk;

    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          free_at = 0;   // first edge at which the serializer may pop
    logic [31:0] mq[$];         // model FIFO contents
    logic [31:0] exp_q[$];      // nonces the model has started transmitting
    logic        m_ovf     = 1'b0;
    logic        m_last_ok = 1'b0;
    logic [31:0] m_last    = '0;
    logic [7:0]  rx_bytes[$];
    logic [7:0]  rx_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare status outputs.
    task automatic step(input logic v, input logic [31:0] d, input logic rst);
        bit dup;
        nonce_valid = v;
        nonce       = d;
        reset       = rst;
        @(posedge hash_clk);
        cyc++;
        if (rst) begin
            mq.delete();
            free_at   = 0;
            m_ovf     = 1'b0;
            m_last_ok = 1'b0;
        end else begin
            if (cyc >= free_at && mq.size() > 0) begin
                exp_q.push_back(mq.pop_front());
                free_at = cyc + FRAME + 1;
            end
            if (v) begin
                dup = DEDUP && m_last_ok && (d == m_last);
                if (!dup) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(d);
                        m_last    = d;
                        m_last_ok = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
        #1;
        check("fifo_count", 32'(fifo_count), mq.size());
        check("busy", 32'(busy), 32'((cyc < free_at - 1) || (mq.size() > 0)));
        check("overflow", 32'(overflow), 32'(m_ovf));
        nonce_valid = 1'b0;
    endtask

    task automatic drain_wait(input string tag);
        int n;
        n = 0;
        while ((mq.size() > 0 || cyc < free_at) && n < 2000) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        check({tag, "_drain_done"}, 32'(n < 2000), 32'd1);
        repeat (45) step(1'b0, '0, 1'b0);
    endtask

    task automatic compare_rx(input string tag);
        logic [31:0] got;
        check({tag, "_rx_bytes"}, rx_bytes.size(), 4 * exp_q.size());
        while (exp_q.size() > 0 && rx_bytes.size() >= 4) begin
            got = {rx_bytes[0], rx_bytes[1], rx_bytes[2], rx_bytes[3]};
            repeat (4) void'(rx_bytes.pop_front());
            check({tag, "_nonce"}, got, exp_q.pop_front());
        end
        rx_bytes.delete();
        exp_q.delete();
    endtask

    // UART receiver: sample the middle of every bit of an 8N1 character.
    initial begin : uart_rx
        forever begin
            @(posedge hash_clk); #1;
            if (tx === 1'b0) begin
                repeat (CPB / 2) @(posedge hash_clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge hash_clk);
                    #1;
                    rx_b[i] = tx;
                end
                repeat (CPB) @(posedge hash_clk);
                #1;
                check("rx_stop_bit", 32'(tx), 32'd1);
                rx_bytes.push_back(rx_b);
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : main
        int          n0;
        int          peak;
        int          n;
        logic [31:0] base;
        logic [31:0] last_sent;
        logic [31:0] d;

        // Reset state
        repeat (3) step(1'b0, '0, 1'b1);
        check("reset_tx", 32'(tx), 32'd1);
        step(1'b0, '0, 1'b0);
        check("idle_tx", 32'(tx), 32'd1);
        rx_bytes.delete();

        // Single nonce: latency, decoded bytes, busy duration
        step(1'b1, 32'hDEADBEEF, 1'b0);
        n0 = cyc;
        check("lat_tx_N", 32'(tx), 32'd1);
        step(1'b0, '0, 1'b0);
        check("lat_tx_N1", 32'(tx), 32'd1);
        step(1'b0, '0, 1'b0);
        check("lat_tx_N2", 32'(tx), 32'd0);
        n = 0;
        while (busy && n < 400) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        check("single_busy_len", cyc - n0, FRAME + 1);
        drain_wait("single");
        check("single_nbytes", rx_bytes.size(), 4);
        if (rx_bytes.size() >= 4) begin
            check("byte0", 32'(rx_bytes[0]), 32'hDE);
            check("byte1", 32'(rx_bytes[1]), 32'hAD);
            check("byte2", 32'(rx_bytes[2]), 32'hBE);
            check("byte3", 32'(rx_bytes[3]), 32'hEF);
        end
        compare_rx("single");

        // Six strobes in a row while idle: one popped, four buffered, one dropped
        base = $urandom;
        peak = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, base + 32'(i), 1'b0);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("ovf_peak", peak, 4);
        check("ovf_flag", 32'(overflow), 32'd1);
        drain_wait("ovf");
        check("ovf_frames", rx_bytes.size() / 4, 5);
        compare_rx("ovf");

        // Full FIFO, strobe exactly on the pop edge
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        rx_bytes.delete();
        exp_q.delete();
        base = $urandom;
        for (int i = 0; i < 5; i++) step(1'b1, base + 32'(i), 1'b0);
        check("full_count", 32'(fifo_count), 32'd4);
        n = 0;
        while (cyc + 1 < free_at && n < 400) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        step(1'b1, base + 32'd100, 1'b0);
        check("popedge_count", 32'(fifo_count), 32'd4);
        check("popedge_ovf", 32'(overflow), 32'd0);
        drain_wait("popedge");
        compare_rx("popedge");

        // Reset in the middle of byte 2 with overflow set
        base = $urandom;
        step(1'b1, base, 1'b0);
        n0 = cyc;
        for (int i = 1; i < 6; i++) step(1'b1, base + 32'(i), 1'b0);
        check("pre_reset_ovf", 32'(overflow), 32'd1);
        while (cyc < n0 + 96) step(1'b0, '0, 1'b0);
        step(1'b1, $urandom, 1'b1);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        step(1'b1, $urandom, 1'b1);
        repeat (50) step(1'b0, '0, 1'b0);
        check("rst_line_idle", 32'(tx), 32'd1);
        rx_bytes.delete();
        exp_q.delete();
        step(1'b1, 32'h00000001, 1'b0);
        drain_wait("after_rst");
        compare_rx("after_rst");

        // Back-to-back nonces: contiguous frames
        step(1'b1, 32'h00000000, 1'b0);
        n0 = cyc;
        step(1'b1, 32'hFFFFFFFF, 1'b0);
        n = 0;
        while (busy && n < 1000) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        check("b2b_len", cyc - n0, 2 * FRAME + 2);
        drain_wait("b2b");
        compare_rx("b2b");

        // Repeated nonce
        step(1'b1, 32'h12345678, 1'b0);
        step(1'b1, 32'h12345678, 1'b0);
        step(1'b1, 32'h12345679, 1'b0);
        drain_wait("dedup");
        check("dedup_frames", rx_bytes.size() / 4, DEDUP ? 2 : 3);
        check("dedup_ovf", 32'(overflow), 32'd0);
        compare_rx("dedup");

        // Randomized traffic, occasionally repeating the previous nonce
        last_sent = 32'h12345679;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                d = ($urandom_range(0, 3) == 0) ? last_sent : $urandom;
                last_sent = d;
                step(1'b1, d, 1'b0);
            end else begin
                step(1'b0, '0, 1'b0);
            end
        end
        drain_wait("random");
        compare_rx("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/nonce_uart_reporter.md
NONCE_UART_REPORTER -- requirements
Module: nonce_uart_reporter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, hash_clk cycles per UART bit; legal range 4..65535.
REQ-002 Parameter FIFO_DEPTH_LOG2, default 2, log2 of nonce FIFO depth; legal range 1..4.
REQ-003 hash_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 nonce_valid  input  1  single-cycle strobe: golden nonce present on nonce.
REQ-006 nonce  input  32  golden nonce value, sampled when nonce_valid=1.
REQ-007 tx  output  1  UART serial line, 8N1, idle high.
REQ-008 busy  output  1  high while a frame is being shifted or the FIFO is non-empty.
REQ-009 overflow  output  1  sticky: a nonce was dropped because the FIFO was full.
REQ-010 fifo_count  output  FIFO_DEPTH_LOG2+1  current FIFO occupancy.

Function
REQ-011 Each cycle with nonce_valid=1 SHALL push nonce into the FIFO unless the push is dropped per REQ-012 or REQ-025.
REQ-012 Push when full with no pop in the same cycle SHALL be dropped and SHALL set overflow; full with a simultaneous pop SHALL accept the push, occupancy unchanged.
REQ-013 Push and pop in the same cycle on an empty FIFO SHALL not occur; pop requires occupancy >= 1 at the start of the cycle.
REQ-014 Serializer FSM states: IDLE, START, DATA, STOP.
REQ-015 IDLE: tx=1; when fifo_count != 0, pop head into 32-bit shift word, byte index 0, go to START.
REQ-016 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-017 DATA: tx=current byte bit, LSB first, each bit held CLKS_PER_BIT cycles; after bit 7 go to STOP.
REQ-018 STOP: tx=1 for CLKS_PER_BIT cycles; if byte index < 3, increment and go to START; else go to IDLE.
REQ-019 Byte order SHALL be MSB byte first: nonce[31:24], [23:16], [15:8], [7:0].
REQ-020 One nonce frame SHALL occupy exactly 40*CLKS_PER_BIT cycles; back-to-back nonces SHALL have zero idle gap beyond one IDLE cycle.
REQ-021 Latency: nonce_valid sampled at edge N with FSM in IDLE and FIFO empty -> pop at edge N+1, tx low from edge N+2.
REQ-022 Bit counter and baud counter widths SHALL not wrap within a bit; baud counter reloads to 0 at CLKS_PER_BIT-1.
REQ-023 busy SHALL equal (state != IDLE) OR (fifo_count != 0).

Reset
REQ-024 reset=1 at an edge SHALL set: state IDLE, tx=1, FIFO empty, fifo_count=0, overflow=0, busy=0; a frame in progress is abandoned, nonce_valid during reset is ignored.

Configuration
REQ-025 With NONCE_DEDUP_EN defined, a push whose nonce equals the last accepted nonce (valid since reset) SHALL be silently dropped without setting overflow; without it, every nonce_valid push is handled per REQ-011/REQ-012.

Structure
REQ-026 Package nonce_report_pkg SHALL hold the FSM state enum, BITS_PER_BYTE=8, BYTES_PER_NONCE=4, and default parameter constants.
REQ-027 FIFO SHALL be a sub-module nonce_fifo (synchronous, registered occupancy, parameterised width/depth); serializer FSM stays in the top module.

Verification
REQ-028 CLKS_PER_BIT=4, single nonce 32'hDEADBEEF when idle -> tx low at N+2; bytes DE,AD,BE,EF decoded 8N1; busy drops after 160 cycles +1.
REQ-029 Depth 4, 6 strobes on consecutive cycles while idle -> 5 transmitted (one popped immediately, four buffered), 1 dropped, overflow=1, fifo_count peaks at 4.
REQ-030 FIFO full with frame ending: strobe on exact pop cycle -> accepted, fifo_count stays 4, overflow stays 0.
REQ-031 Reset asserted mid DATA of byte 2 -> tx=1 next cycle, fifo_count=0, overflow=0; subsequent nonce 32'h00000001 transmitted correctly.
REQ-032 NONCE_DEDUP_EN defined, strobes 32'h12345678 twice then 32'h12345679 -> two frames, overflow=0; undefined -> three frames.
REQ-033 Two nonces back-to-back (32'h00000000, 32'hFFFFFFFF) -> frames contiguous, total 80*CLKS_PER_BIT+2 cycles from first strobe to final stop-bit end.
